grid_ascii_dumper: RTL and testbench

Downstream consumer of the silife core's row-read port. On a start pulse it walks rows 0..ROWS-1 and renders each row as ASCII, one byte per cell ('#' live, '.' dead), followed by CR LF. It feeds the bytes over a valid/ready byte stream into the UART transmitter. This replaces the ad-hoc grid-dump logic in the FPGA top level with a self-contained, flow-controlled block.

---
 rtl/grid_ascii_dumper.sv | 107 ++++++++++
 tb/tb_grid_ascii_dumper.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/grid_ascii_dumper.sv
// rtl/grid_ascii_dumper.sv - renders the cell grid as ASCII rows over a valid/ready byte stream
module grid_ascii_dumper #(
   parameter int ROWS = 32,
   parameter int COLS = 8,
   parameter int ROW_W = 5,
   parameter logic [7:0] LIVE_CHAR = 8'h23,
   parameter logic [7:0] DEAD_CHAR = 8'h2E
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [ROW_W-1:0] row_sel,
   input  logic [COLS-1:0]  row_data,
   output logic [7:0]       out_byte,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, CELLS, CR, LF} state_t;

   state_t           state, state_nxt;
   logic [COL_W-1:0] col;
   logic [COLS-1:0]  shadow;
   logic             done_nxt;
   logic             xfer;
   logic             last_row;
   logic             last_col;

   assign xfer     = out_valid && out_ready;
   assign last_row = (row_sel == ROW_W'(ROWS - 1));
   assign last_col = (col == COL_W'(COLS - 1));
   assign busy     = (state != IDLE);

   // Abort only takes effect at a byte boundary, so a pending byte is never retracted.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      out_valid = 1'b0;
      out_byte  = 8'h00;
      case (state)
         IDLE: begin
            if (start) state_nxt = SETUP;
         end
         SETUP: begin
            state_nxt = abort ? IDLE : CELLS;
         end
         CELLS: begin
            out_valid = 1'b1;
            out_byte  = shadow[col] ? LIVE_CHAR : DEAD_CHAR;
            if (xfer) begin
               if (abort)         state_nxt = IDLE;
               else if (last_col) state_nxt = CR;
            end
         end
         CR: begin
            out_valid = 1'b1;
            out_byte  = 8'h0D;
            if (xfer) state_nxt = abort ? IDLE : LF;
         end
         LF: begin
            out_valid = 1'b1;
            out_byte  = 8'h0A;
            if (xfer) begin
               if (abort) begin
                  state_nxt = IDLE;
               end else if (last_row) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = SETUP;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         done    <= 1'b0;
         row_sel <= '0;
         col     <= '0;
         shadow  <= '0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         if (state == IDLE && start)
            row_sel <= '0;
         // Shadowing the row makes the emitted bytes immune to grid updates mid-row.
         if (state == SETUP) begin
            shadow <= row_data;
            col    <= '0;
         end
         if (state == CELLS && xfer && !last_col)
            col <= col + COL_W'(1);
         if (state == LF && xfer && !abort && !last_row)
            row_sel <= row_sel + ROW_W'(1);
      end
   end

endmodule

// File: tb/tb_grid_ascii_dumper.sv
// tb/tb_grid_ascii_dumper.sv - directed self-checking bench for grid_ascii_dumper
module tb_grid_ascii_dumper;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy;
   logic       done;
   logic [4:0] row_sel;
   logic [7:0] row_data;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       ovr = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [7:0] got[$];
   int done_cnt, done_cyc, first_valid, stable_err;

   grid_ascii_dumper dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .row_sel(row_sel), .row_data(row_data), .out_byte(out_byte),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   assign row_data = ovr ? 8'hFF : 8'(row_sel);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_errs();
      int e = 0;
      for (int i = 0; i < got.size(); i++) begin
         int r = i / 10;
         int c = i % 10;
         logic [7:0] rb = 8'(r);
         logic [7:0] x;
         if (c < 8) x = rb[c] ? 8'h23 : 8'h2E;
         else       x = (c == 8) ? 8'h0D : 8'h0A;
         if (got[i] !== x) e++;
      end
      return e;
   endfunction

   // Caller raises start on a negedge (cycle 0); n counts the following cycles.
   task automatic watch(input bit bp, input int budget, input int inj_start_n, input int abort_at,
                        input int rst_at, input int ovr_until, input bit start_on_done);
      logic pv = 1'b0;
      logic pr = 1'b0;
      logic [7:0] pb = 8'h00;
      bit fin = 1'b0;
      got.delete();
      done_cnt = 0; done_cyc = -1; first_valid = -1; stable_err = 0;
      for (int n = 1; n <= budget && !fin; n++) begin
         @(negedge clk);
         rst = 1'b0; start = 1'b0; abort = 1'b0;
         if (pv && !pr && (!out_valid || out_byte !== pb)) stable_err++;
         if (done) begin done_cnt++; done_cyc = n; end
         if (!busy && n >= 2) begin
            fin = 1'b1;
            ovr = 1'b0;
            if (start_on_done && done) start = 1'b1;
         end else begin
            start = (n == inj_start_n);
            ovr = (ovr_until > 0 && n >= 2 && got.size() < ovr_until);
            abort = (abort_at >= 0 && got.size() == abort_at);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && first_valid < 0) first_valid = n;
            if (rst_at >= 0 && got.size() == rst_at && out_valid) rst = 1'b1;
            else if (out_valid && out_ready) got.push_back(out_byte);
            pv = out_valid; pr = out_ready; pb = out_byte;
         end
      end
      chk("watch_terminated", 32'(fin), 1);
      out_ready = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_byte", 32'(out_byte), 0);
      chk("rst_row_sel", 32'(row_sel), 0);

      @(negedge clk); start = 1'b1;
      watch(1'b0, 2000, -1, -1, -1, 0, 1'b0);
      chk("full_len", got.size(), 320);
      chk("full_bytes", model_errs(), 0);
      chk("full_first_valid", first_valid, 2);
      chk("full_done_cyc", done_cyc, 353);
      chk("full_done_cnt", done_cnt, 1);
      chk("full_busy_after", 32'(busy), 0);
      chk("row0_c0", 32'(got[0]), 32'h2E);
      chk("row0_cr", 32'(got[8]), 32'h0D);
      chk("row0_lf", 32'(got[9]), 32'h0A);
      chk("row3_c0", 32'(got[30]), 32'h23);
      chk("row3_c1", 32'(got[31]), 32'h23);
      chk("row3_c2", 32'(got[32]), 32'h2E);

      @(negedge clk); start = 1'b1;
      watch(1'b1, 5000, -1, -1, -1, 0, 1'b0);
      chk("bp_len", got.size(), 320);
      chk("bp_bytes", model_errs(), 0);
      chk("bp_stable", stable_err, 0);
      chk("bp_done_cnt", done_cnt, 1);

      @(negedge clk); start = 1'b1;
      watch(1'b0, 2000, -1, -1, -1, 8, 1'b0);
      chk("iso_row0_c3", 32'(got[3]), 32'h2E);
      chk("iso_row0_c7", 32'(got[7]), 32'h2E);
      chk("iso_bytes", model_errs(), 0);

      @(negedge clk); start = 1'b1;
      watch(1'b0, 2000, -1, 53, -1, 0, 1'b0);
      chk("abort_len", got.size(), 54);
      chk("abort_last", 32'(got[53]), 32'h2E);
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_row_sel", 32'(row_sel), 5);

      @(negedge clk); start = 1'b1;
      watch(1'b0, 2000, -1, -1, 108, 0, 1'b0);
      chk("rstmid_len", got.size(), 108);
      chk("rstmid_valid", 32'(out_valid), 0);
      chk("rstmid_row_sel", 32'(row_sel), 0);
      chk("rstmid_busy", 32'(busy), 0);
      chk("rstmid_done_cnt", done_cnt, 0);
      @(negedge clk); start = 1'b1;
      watch(1'b0, 2000, -1, -1, -1, 0, 1'b0);
      chk("after_rst_len", got.size(), 320);
      chk("after_rst_bytes", model_errs(), 0);

      @(negedge clk); start = 1'b1;
      watch(1'b0, 2000, 30, -1, -1, 0, 1'b1);
      chk("busy_start_len", got.size(), 320);
      chk("busy_start_done_cyc", done_cyc, 353);
      chk("busy_start_done_cnt", done_cnt, 1);
      watch(1'b0, 2000, -1, -1, -1, 0, 1'b0);
      chk("redump_len", got.size(), 320);
      chk("redump_bytes", model_errs(), 0);
      chk("redump_first_valid", first_valid, 2);
      chk("redump_done_cyc", done_cyc, 353);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
